// File: rtl/sm4_pkg.sv
// Shared SM4 types, constants and round helpers used by sm4_en and sm4_cbc_enc.
package sm4_pkg;

    localparam int unsigned SM4_BLK_W = 128;

    typedef logic [SM4_BLK_W-1:0] sm4_block_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        CALC,
        OUT
    } sm4_cbc_state_e;

    // S-box, byte 0x00 in the most significant position.
    localparam logic [2047:0] SM4_SBOX = {
        128'hd690e9fecce13db716b614c228fb2c05,
        128'h2b679a762abe04c3aa44132649860699,
        128'h9c4250f491ef987a33540b43edcfac62,
        128'he4b31ca9c908e89580df94fa758f3fa6,
        128'h4707a7fcf37317ba83593c19e6854fa8,
        128'h686b81b27164da8bf8eb0f4b70569d35,
        128'h1e240e5e6358d1a225227c3b01217887,
        128'hd40046579fd327524c3602e7a0c4c89e,
        128'heabf8ad240c738b5a3f7f2cef96115a1,
        128'he0ae5da49b341a55ad933230f58cb1e3,
        128'h1df6e22e8266ca60c02923ab0d534e6f,
        128'hd5db3745defd8e2f03ff6a726d6c5b51,
        128'h8d1baf92bbddbc7f11d95c411f105ad8,
        128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
        128'h8969974a0c96777e65b9f109c56ec684,
        128'h18f07dec3adc4d2079ee5f3ed7cb3948
    };

    // System parameter FK, word 0 in the top bits.
    localparam logic [127:0] SM4_FK = 128'ha3b1bac656aa3350677d9197b27022dc;

    function automatic logic [7:0] sm4_sbox(input logic [7:0] a);
        return SM4_SBOX[8*(255-int'(a)) +: 8];
    endfunction

    function automatic logic [31:0] sm4_rol(input logic [31:0] v, input int unsigned n);
        return (v << n) | (v >> (32 - n));
    endfunction

    // Non-linear byte substitution tau.
    function automatic logic [31:0] sm4_tau(input logic [31:0] a);
        logic [31:0] b;
        for (int j = 0; j < 4; j++) begin
            b[8*j +: 8] = sm4_sbox(a[8*j +: 8]);
        end
        return b;
    endfunction

    // Data-path round transform T = L(tau(.)).
    function automatic logic [31:0] sm4_t(input logic [31:0] a);
        logic [31:0] b;
        b = sm4_tau(a);
        return b ^ sm4_rol(b, 2) ^ sm4_rol(b, 10) ^ sm4_rol(b, 18) ^ sm4_rol(b, 24);
    endfunction

    // Key-schedule round transform T' = L'(tau(.)).
    function automatic logic [31:0] sm4_tk(input logic [31:0] a);
        logic [31:0] b;
        b = sm4_tau(a);
        return b ^ sm4_rol(b, 13) ^ sm4_rol(b, 23);
    endfunction

    // Fixed parameter CK[i]: byte j equals (4i+j)*7 mod 256.
    function automatic logic [31:0] sm4_ck(input int unsigned i);
        logic [31:0] ck;
        for (int unsigned j = 0; j < 4; j++) begin
            ck[31-8*j -: 8] = 8'((4*i + j) * 7);
        end
        return ck;
    endfunction

endpackage

// File: rtl/sm4_en.sv
// Combinational SM4 block encryptor: full key expansion and 32 rounds in one cone.
module sm4_en
    import sm4_pkg::*;
(
    input  logic [SM4_BLK_W-1:0] data_in,
    input  logic [SM4_BLK_W-1:0] key,
    output logic [SM4_BLK_W-1:0] data_out
);

    function automatic sm4_block_t sm4_encrypt(input sm4_block_t pt, input sm4_block_t mk);
        logic [31:0] k [36];
        logic [31:0] x [36];
        for (int i = 0; i < 4; i++) begin
            k[i] = mk[127-32*i -: 32] ^ SM4_FK[127-32*i -: 32];
            x[i] = pt[127-32*i -: 32];
        end
        for (int i = 0; i < 32; i++) begin
            // k[i+4] is round key rk[i]
            k[i+4] = k[i] ^ sm4_tk(k[i+1] ^ k[i+2] ^ k[i+3] ^ sm4_ck(i));
            x[i+4] = x[i] ^ sm4_t(x[i+1] ^ x[i+2] ^ x[i+3] ^ k[i+4]);
        end
        // Final reverse transform R.
        return {x[35], x[34], x[33], x[32]};
    endfunction

    assign data_out = sm4_encrypt(data_in, key);

endmodule

// File: rtl/sm4_cbc_enc.sv
// Sequential CBC (or ECB) wrapper around the combinational sm4_en core.
// Build option: define SM4_CBC_CHAIN_EN for CBC chaining; undefined gives ECB.
module sm4_cbc_enc
    import sm4_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cfg_valid,
    input  logic [SM4_BLK_W-1:0] cfg_key,
    input  logic [SM4_BLK_W-1:0] cfg_iv,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [SM4_BLK_W-1:0] in_data,
    input  logic                 in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [SM4_BLK_W-1:0] out_data,
    output logic                 out_last,
    output logic                 busy,
    output logic [CNT_W-1:0]     blk_cnt
);

    sm4_cbc_state_e state_q, state_d;

    sm4_block_t       key_q, key_d;
    sm4_block_t       blk_q, blk_d;
    logic             last_q, last_d;
    sm4_block_t       out_data_q, out_data_d;
    logic             out_last_q, out_last_d;
    logic             out_valid_q, out_valid_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    sm4_block_t       enc_result;

`ifdef SM4_CBC_CHAIN_EN
    sm4_block_t chain_q, chain_d;
`else
    // IV has no meaning without chaining.
    logic unused_iv;
    assign unused_iv = ^cfg_iv;
`endif

    // Key expansion is fed from key_q, so it settles while in RUN.
    sm4_en u_sm4_en (
        .data_in  (blk_q),
        .key      (key_q),
        .data_out (enc_result)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (cfg_valid) state_d = RUN;
            RUN:     if (in_valid) state_d = CALC;
            CALC:    state_d = OUT;
            OUT:     if (out_ready) state_d = out_last_q ? IDLE : RUN;
            default: state_d = IDLE;
        endcase
    end

    // State-decoded outputs.
    always_comb begin
        in_ready = (state_q == RUN);
        busy     = (state_q != IDLE);
    end

    // Datapath next-state: config load, block capture, result capture, counter.
    always_comb begin
        key_d       = key_q;
        blk_d       = blk_q;
        last_d      = last_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        out_valid_d = out_valid_q;
        cnt_d       = cnt_q;
`ifdef SM4_CBC_CHAIN_EN
        chain_d     = chain_q;
`endif
        case (state_q)
            IDLE: begin
                if (cfg_valid) begin
                    key_d = cfg_key;
                    cnt_d = '0;
`ifdef SM4_CBC_CHAIN_EN
                    chain_d = cfg_iv;
`endif
                end
            end
            RUN: begin
                if (in_valid) begin
`ifdef SM4_CBC_CHAIN_EN
                    blk_d = in_data ^ chain_q;
`else
                    blk_d = in_data;
`endif
                    last_d = in_last;
                end
            end
            CALC: begin
                out_data_d  = enc_result;
                out_last_d  = last_q;
                out_valid_d = 1'b1;
`ifdef SM4_CBC_CHAIN_EN
                chain_d     = enc_result;
`endif
            end
            OUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    // Saturate rather than wrap so a long message never reads as short.
                    if (cnt_q != '1) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    // Datapath registers; an asynchronous reset discards any in-flight block.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_q       <= '0;
            blk_q       <= '0;
            last_q      <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            out_valid_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            key_q       <= key_d;
            blk_q       <= blk_d;
            last_q      <= last_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            out_valid_q <= out_valid_d;
            cnt_q       <= cnt_d;
        end
    end

`ifdef SM4_CBC_CHAIN_EN
    // Chaining value: IV at config, then each ciphertext.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain_q <= '0;
        end else begin
            chain_q <= chain_d;
        end
    end
`endif

    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign out_valid = out_valid_q;
    assign blk_cnt   = cnt_q;

endmodule

// File: tb/tb_sm4_cbc_enc.sv
// Self-checking bench for sm4_cbc_enc against a behavioural SM4 / CBC / ECB model.
module tb_sm4_cbc_enc;

    localparam int unsigned CNT_W = 2;
    localparam logic [127:0] STD_KEY = 128'h0123456789abcdeffedcba9876543210;
    localparam logic [127:0] STD_CT  = 128'h681edf34d206965e86b3e94f536e4246;

    localparam logic [2047:0] SBOX = {
        128'hd690e9fecce13db716b614c228fb2c05, 128'h2b679a762abe04c3aa44132649860699,
        128'h9c4250f491ef987a33540b43edcfac62, 128'he4b31ca9c908e89580df94fa758f3fa6,
        128'h4707a7fcf37317ba83593c19e6854fa8, 128'h686b81b27164da8bf8eb0f4b70569d35,
        128'h1e240e5e6358d1a225227c3b01217887, 128'hd40046579fd327524c3602e7a0c4c89e,
        128'heabf8ad240c738b5a3f7f2cef96115a1, 128'he0ae5da49b341a55ad933230f58cb1e3,
        128'h1df6e22e8266ca60c02923ab0d534e6f, 128'hd5db3745defd8e2f03ff6a726d6c5b51,
        128'h8d1baf92bbddbc7f11d95c411f105ad8, 128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
        128'h8969974a0c96777e65b9f109c56ec684, 128'h18f07dec3adc4d2079ee5f3ed7cb3948
    };
    localparam logic [127:0] FK = 128'ha3b1bac656aa3350677d9197b27022dc;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             cfg_valid;
    logic [127:0]     cfg_key;
    logic [127:0]     cfg_iv;
    logic             in_valid;
    logic             in_ready;
    logic [127:0]     in_data;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [127:0]     out_data;
    logic             out_last;
    logic             busy;
    logic [CNT_W-1:0] blk_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state.
    logic [127:0] m_key;
    logic [127:0] m_chain;
    int           m_cnt;

    always #5 clk = ~clk;

    sm4_cbc_enc #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_valid (cfg_valid),
        .cfg_key   (cfg_key),
        .cfg_iv    (cfg_iv),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy),
        .blk_cnt   (blk_cnt)
    );

    // ---------------- behavioural model ----------------
    function automatic logic [31:0] rol(input logic [31:0] v, input int n);
        return (v << n) | (v >> (32 - n));
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] a);
        logic [31:0] b;
        int idx;
        for (int j = 0; j < 4; j++) begin
            idx = int'(a[8*j +: 8]);
            b[8*j +: 8] = SBOX[2047 - 8*idx -: 8];
        end
        return b;
    endfunction

    function automatic logic [127:0] ref_enc(input logic [127:0] pt, input logic [127:0] mk);
        logic [31:0] k [36];
        logic [31:0] x [36];
        logic [31:0] t;
        logic [31:0] ck;
        for (int i = 0; i < 4; i++) begin
            k[i] = mk[127-32*i -: 32] ^ FK[127-32*i -: 32];
            x[i] = pt[127-32*i -: 32];
        end
        for (int i = 0; i < 32; i++) begin
            for (int j = 0; j < 4; j++) ck[31-8*j -: 8] = 8'(((4*i + j) * 7) % 256);
            t = sub_word(k[i+1] ^ k[i+2] ^ k[i+3] ^ ck);
            k[i+4] = k[i] ^ t ^ rol(t, 13) ^ rol(t, 23);
            t = sub_word(x[i+1] ^ x[i+2] ^ x[i+3] ^ k[i+4]);
            x[i+4] = x[i] ^ t ^ rol(t, 2) ^ rol(t, 10) ^ rol(t, 18) ^ rol(t, 24);
        end
        return {x[35], x[34], x[33], x[32]};
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [CNT_W-1:0] exp_cnt(input int n);
        int sat;
        sat = (1 << CNT_W) - 1;
        return CNT_W'((n > sat) ? sat : n);
    endfunction

    task automatic model_step(input logic [127:0] pt, output logic [127:0] ct);
`ifdef SM4_CBC_CHAIN_EN
        ct = ref_enc(pt ^ m_chain, m_key);
        m_chain = ct;
`else
        ct = ref_enc(pt, m_key);
`endif
        m_cnt++;
    endtask

    // ---------------- drivers ----------------
    task automatic do_cfg(input logic [127:0] key, input logic [127:0] iv);
        @(negedge clk);
        cfg_valid = 1'b1;
        cfg_key   = key;
        cfg_iv    = iv;
        @(negedge clk);
        cfg_valid = 1'b0;
        cfg_key   = rand128();
        cfg_iv    = rand128();
        m_key   = key;
        m_chain = iv;
        m_cnt   = 0;
    endtask

    // One block through the DUT; ok drops if either handshake never arrives.
    task automatic xfer(input logic [127:0] pt, input logic lst, input int stall,
                        output logic [127:0] ct, output logic ct_last, output bit ok);
        int n;
        ok       = 1'b1;
        in_valid = 1'b1;
        in_data  = pt;
        in_last  = lst;
        n = 0;
        while (in_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        if (in_ready !== 1'b1) ok = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = rand128();
        in_last  = 1'($urandom);
        n = 0;
        while (out_valid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        if (out_valid !== 1'b1) ok = 1'b0;
        repeat (stall) @(negedge clk);
        ct      = out_data;
        ct_last = out_last;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({in_ready, out_valid, out_last, busy} !== 4'b0)
            $display("FAIL reset_flags: got %b want 0000", {in_ready, out_valid, out_last, busy});
        else n_pass++;
        n_checks++;
        if (out_data !== 128'h0) $display("FAIL reset_data: got %h want 0", out_data);
        else n_pass++;
        n_checks++;
        if (blk_cnt !== '0) $display("FAIL reset_cnt: got %0d want 0", blk_cnt);
        else n_pass++;
        rst_n = 1'b1;
        // No config yet: in_valid must be ignored.
        in_valid = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b0 || busy !== 1'b0)
            $display("FAIL idle_ignore: got ready=%b busy=%b want 0 0", in_ready, busy);
        else n_pass++;
        in_valid = 1'b0;
    endtask

    task automatic test_std_vector();
        logic [127:0] exp;
        do_cfg(STD_KEY, 128'h0);
        n_checks++;
        if (in_ready !== 1'b1 || busy !== 1'b1)
            $display("FAIL cfg_to_run: got ready=%b busy=%b want 1 1", in_ready, busy);
        else n_pass++;
        in_valid = 1'b1;
        in_data  = STD_KEY;
        in_last  = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        model_step(STD_KEY, exp);
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0)
            $display("FAIL calc_cycle: got valid=%b ready=%b want 0 0", out_valid, in_ready);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== STD_CT || out_last !== 1'b1)
            $display("FAIL std_vector: got v=%b %h l=%b want 1 %h 1", out_valid, out_data,
                     out_last, STD_CT);
        else n_pass++;
        n_checks++;
        if (out_data !== exp) $display("FAIL std_model: got %h want %h", out_data, exp);
        else n_pass++;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        n_checks++;
        if (blk_cnt !== exp_cnt(1) || busy !== 1'b0 || out_valid !== 1'b0)
            $display("FAIL std_done: got cnt=%0d busy=%b v=%b want 1 0 0", blk_cnt, busy,
                     out_valid);
        else n_pass++;
    endtask

    task automatic test_chaining();
        logic [127:0] ct1, ct2, e1, e2;
        logic         l1, l2;
        bit           ok1, ok2;
        do_cfg(STD_KEY, 128'h0);
        model_step(STD_KEY, e1);
        xfer(STD_KEY, 1'b0, 0, ct1, l1, ok1);
        model_step(STD_KEY ^ STD_CT, e2);
        xfer(STD_KEY ^ STD_CT, 1'b1, 0, ct2, l2, ok2);
        n_checks++;
        if (!ok1 || ct1 !== e1 || l1 !== 1'b0)
            $display("FAIL chain_blk1: got ok=%b %h l=%b want 1 %h 0", ok1, ct1, l1, e1);
        else n_pass++;
        n_checks++;
        if (!ok2 || ct2 !== e2 || l2 !== 1'b1)
            $display("FAIL chain_blk2: got ok=%b %h l=%b want 1 %h 1", ok2, ct2, l2, e2);
        else n_pass++;
`ifdef SM4_CBC_CHAIN_EN
        n_checks++;
        if (ct2 !== STD_CT) $display("FAIL chain_repeat: got %h want %h", ct2, STD_CT);
        else n_pass++;
`endif
    endtask

    task automatic test_backpressure();
        logic [127:0] pt, exp, held, ct;
        logic         l;
        bit           ok, stable, ready_low, cnt_same;
        do_cfg(rand128(), rand128());
        pt = rand128();
        model_step(pt, exp);
        in_valid = 1'b1;
        in_data  = pt;
        in_last  = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        held      = out_data;
        stable    = 1'b1;
        ready_low = 1'b1;
        cnt_same  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_data !== held || out_valid !== 1'b1) stable = 1'b0;
            if (in_ready !== 1'b0) ready_low = 1'b0;
            if (blk_cnt !== exp_cnt(0)) cnt_same = 1'b0;
        end
        n_checks++;
        if (!stable || held !== exp) $display("FAIL bp_hold: got %h stable=%b want %h", held,
                                              stable, exp);
        else n_pass++;
        n_checks++;
        if (!ready_low) $display("FAIL bp_ready: got in_ready high want low");
        else n_pass++;
        n_checks++;
        if (!cnt_same) $display("FAIL bp_cnt: got changing count want 0");
        else n_pass++;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        n_checks++;
        if (blk_cnt !== exp_cnt(1) || out_valid !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL bp_release: got cnt=%0d v=%b r=%b want 1 0 1", blk_cnt, out_valid,
                     in_ready);
        else n_pass++;
        pt = rand128();
        model_step(pt, exp);
        xfer(pt, 1'b1, 0, ct, l, ok);
        n_checks++;
        if (!ok || ct !== exp) $display("FAIL bp_next: got %h want %h", ct, exp);
        else n_pass++;
    endtask

    task automatic test_ignored_cfg();
        logic [127:0] pt, exp, ct;
        logic         l;
        bit           ok;
        do_cfg(rand128(), rand128());
        // Hold a different config throughout RUN/CALC/OUT.
        cfg_valid = 1'b1;
        cfg_key   = rand128();
        cfg_iv    = rand128();
        for (int b = 0; b < 2; b++) begin
            pt = rand128();
            model_step(pt, exp);
            xfer(pt, 1'(b == 1), 2, ct, l, ok);
            n_checks++;
            if (!ok || ct !== exp) $display("FAIL ignored_cfg_blk%0d: got %h want %h", b, ct, exp);
            else n_pass++;
        end
        cfg_valid = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || blk_cnt !== exp_cnt(2))
            $display("FAIL ignored_cfg_end: got busy=%b cnt=%0d want 0 2", busy, blk_cnt);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        bit quiet;
        do_cfg(rand128(), rand128());
        in_valid = 1'b1;
        in_data  = rand128();
        in_last  = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        // DUT is in CALC here.
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({in_ready, out_valid, out_last, busy} !== 4'b0 || out_data !== 128'h0 ||
            blk_cnt !== '0)
            $display("FAIL reset_mid: got r=%b v=%b l=%b b=%b d=%h c=%0d want all 0", in_ready,
                     out_valid, out_last, busy, out_data, blk_cnt);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        in_valid = 1'b1;
        quiet = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (in_ready !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0) quiet = 1'b0;
        end
        in_valid = 1'b0;
        n_checks++;
        if (!quiet) $display("FAIL reset_mid_idle: got activity after reset want none");
        else n_pass++;
    endtask

    task automatic test_saturation();
        logic [127:0] pt, exp, ct;
        logic         l;
        bit           ok;
        do_cfg(rand128(), rand128());
        for (int b = 1; b <= 5; b++) begin
            pt = rand128();
            model_step(pt, exp);
            xfer(pt, 1'(b == 5), 0, ct, l, ok);
            n_checks++;
            if (!ok || ct !== exp) $display("FAIL sat_data%0d: got %h want %h", b, ct, exp);
            else n_pass++;
            n_checks++;
            if (blk_cnt !== exp_cnt(m_cnt))
                $display("FAIL sat_cnt%0d: got %0d want %0d", b, blk_cnt, exp_cnt(m_cnt));
            else n_pass++;
        end
    endtask

    task automatic test_random();
        logic [127:0] pt, exp, ct;
        logic         l;
        bit           ok;
        int           len;
        for (int m = 0; m < 4; m++) begin
            do_cfg(rand128(), rand128());
            len = int'($urandom_range(1, 4));
            for (int b = 0; b < len; b++) begin
                pt = rand128();
                model_step(pt, exp);
                xfer(pt, 1'(b == len - 1), int'($urandom_range(0, 3)), ct, l, ok);
                n_checks++;
                if (!ok || ct !== exp || l !== 1'(b == len - 1) || blk_cnt !== exp_cnt(m_cnt))
                    $display("FAIL rand_m%0d_b%0d: got %h l=%b c=%0d want %h l=%b c=%0d", m, b,
                             ct, l, blk_cnt, exp, b == len - 1, exp_cnt(m_cnt));
                else n_pass++;
            end
            n_checks++;
            if (busy !== 1'b0) $display("FAIL rand_m%0d_idle: got busy=%b want 0", m, busy);
            else n_pass++;
        end
    endtask

    initial begin
        cfg_valid = 1'b0;
        cfg_key   = '0;
        cfg_iv    = '0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        m_key     = '0;
        m_chain   = '0;
        m_cnt     = 0;
        test_reset();
        test_std_vector();
        test_chaining();
        test_backpressure();
        test_ignored_cfg();
        test_reset_mid();
        test_saturation();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish before 200us");
        $fatal(1, "timeout");
    end

endmodule
